// File: rtl/crg_out_packer_pkg.sv
// crg_out_packer_pkg: shared word type, beat width helper and packer FSM states.
// Contents: LEN_PRNG/prng_t (upstream word), OUT_W (default packed beat width),
// out_w() (beat width for any words-per-beat), pkr_state_t (packer FSM states).
package crg_out_packer_pkg;
    localparam int LEN_PRNG = 32;
    typedef logic [LEN_PRNG-1:0] prng_t;
    localparam int WORDS_PER_BEAT_DEF = 4;
    localparam int OUT_W = WORDS_PER_BEAT_DEF * LEN_PRNG;
    typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} pkr_state_t;
    function automatic int out_w(input int words);
        return words * LEN_PRNG;
    endfunction
endpackage

// File: rtl/crg_out_packer_beat_fifo.sv
// beat_fifo: synchronous FIFO of {last, data} beats with full/empty flags.
// Ports: clk_i/rst_i clock and sync reset; push/din write side; pop/dout read
// side (dout is the head entry); full/empty occupancy flags.
module beat_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         push,
    input  logic [W-1:0] din,
    input  logic         pop,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty
);
    localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wptr, rptr;
    logic [CW-1:0] count;
    logic          wr, rd;
    function automatic logic [AW-1:0] nxt(input logic [AW-1:0] p);
        return p == AW'(DEPTH - 1) ? '0 : p + 1'b1;
    endfunction
    assign full  = count == CW'(DEPTH);
    assign empty = count == '0;
    assign wr    = push && !full;
    assign rd    = pop && !empty;
    assign dout  = mem[rptr];
    always_ff @(posedge clk_i)
        if (wr) mem[wptr] <= din;
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (wr) wptr <= nxt(wptr);
            if (rd) rptr <= nxt(rptr);
            count <= count + CW'(wr) - CW'(rd);
        end
    end
endmodule

// File: rtl/crg_out_packer.sv
// crg_out_packer: packs upstream prng_t words into WORDS_PER_BEAT-wide beats for a run of nbeats.
// Ports: clk_i/rst_i clock and sync reset; start_i/nbeats_i run request;
// z_i/z_valid_i/z_ready_o word input; m_data_o/m_valid_o/m_last_o/m_ready_i
// beat output; busy_o not idle; done_o one-cycle run completion pulse.
module crg_out_packer
    import crg_out_packer_pkg::*;
#(
    parameter int WORDS_PER_BEAT = 4,
    parameter int FIFO_DEPTH     = 4
) (
    input  logic                                clk_i,
    input  logic                                rst_i,
    input  logic                                start_i,
    input  logic [15:0]                         nbeats_i,
    input  prng_t                               z_i,
    input  logic                                z_valid_i,
    output logic                                z_ready_o,
    output logic [WORDS_PER_BEAT*LEN_PRNG-1:0]  m_data_o,
    output logic                                m_valid_o,
    output logic                                m_last_o,
    input  logic                                m_ready_i,
    output logic                                busy_o,
    output logic                                done_o
);
    localparam int BW = out_w(WORDS_PER_BEAT);
    localparam int LW = WORDS_PER_BEAT > 1 ? $clog2(WORDS_PER_BEAT) : 1;
    pkr_state_t    state;
    logic [15:0]   nbeats, beat_cnt;
    logic [LW-1:0] lane;
    logic [BW-1:0] acc, beat;
    logic [BW:0]   head;
    logic          take, last_lane, push, is_last, full, empty;
    assign z_ready_o = state == RUN && !full;
    assign take      = z_valid_i && z_ready_o;
    assign last_lane = lane == LW'(WORDS_PER_BEAT - 1);
    assign push      = take && last_lane;
    assign is_last   = beat_cnt == nbeats - 16'd1;
    assign m_valid_o = !empty;
    // Head storage is not reset, so mask it until a real beat is present.
    assign m_data_o  = empty ? '0 : head[BW-1:0];
    assign m_last_o  = !empty && head[BW];
    assign busy_o    = state != IDLE;
    // Completed beat includes the word arriving this cycle in the final lane.
    always_comb begin
        beat = acc;
        beat[lane*LEN_PRNG +: LEN_PRNG] = z_i;
    end
    beat_fifo #(.W(BW + 1), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .push  (push),
        .din   ({is_last, beat}),
        .pop   (m_valid_o && m_ready_i),
        .dout  (head),
        .full  (full),
        .empty (empty)
    );
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state    <= IDLE;
            nbeats   <= '0;
            beat_cnt <= '0;
            lane     <= '0;
            acc      <= '0;
            done_o   <= 1'b0;
        end else begin
            done_o <= state == DONE;
            if (take) begin
                acc  <= beat;
                lane <= last_lane ? '0 : lane + 1'b1;
            end
            if (push) beat_cnt <= beat_cnt + 16'd1;
            case (state)
                IDLE:
                    if (start_i) begin
                        nbeats   <= nbeats_i;
                        beat_cnt <= '0;
                        lane     <= '0;
                        state    <= nbeats_i == '0 ? DONE : RUN;
                    end
                RUN:     if (push && is_last) state <= FLUSH;
                FLUSH:   if (empty) state <= DONE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_crg_out_packer.sv
// tb_crg_out_packer: randomized self-checking bench with a word-queue beat model.
module tb_crg_out_packer;
    import crg_out_packer_pkg::*;
    localparam int WPB = 4;
    localparam int BW  = WPB * LEN_PRNG;
    logic          clk = 1'b0;
    logic          rst, start, z_valid, z_ready, m_valid, m_last, m_ready, busy, done;
    logic [15:0]   nbeats;
    prng_t         z;
    logic [BW-1:0] m_data;
    int            total = 0, bad = 0;
    prng_t         words[$];
    int            run_n, got_beats, done_cnt = 0;
    bit            stall_prev, last_acc, mv_seen, zr_seen;
    logic [BW-1:0] stall_data;
    logic          stall_last;

    always #5 clk = ~clk;

    crg_out_packer #(.WORDS_PER_BEAT(WPB), .FIFO_DEPTH(4)) dut (
        .clk_i     (clk),
        .rst_i     (rst),
        .start_i   (start),
        .nbeats_i  (nbeats),
        .z_i       (z),
        .z_valid_i (z_valid),
        .z_ready_o (z_ready),
        .m_data_o  (m_data),
        .m_valid_o (m_valid),
        .m_last_o  (m_last),
        .m_ready_i (m_ready),
        .busy_o    (busy),
        .done_o    (done)
    );

    task automatic chk(input string tag, input logic [BW-1:0] got, input logic [BW-1:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Observe handshakes at the falling edge, then advance past the next rising edge.
    task automatic tick();
        logic [BW-1:0] e;
        int b;
        @(negedge clk);
        last_acc = z_valid && z_ready;
        if (last_acc) words.push_back(z);
        if (m_valid === 1'b1) mv_seen = 1;
        if (z_ready === 1'b1) zr_seen = 1;
        if (stall_prev) begin
            chk("stall_valid", BW'(m_valid), BW'(1));
            chk("stall_data", m_data, stall_data);
            chk("stall_last", BW'(m_last), BW'(stall_last));
        end
        if (m_valid === 1'b1 && m_ready === 1'b1) begin
            b = got_beats;
            if (b * WPB + WPB > words.size())
                chk("extra_beat", BW'(b), BW'(words.size() / WPB));
            else begin
                e = '0;
                for (int k = 0; k < WPB; k++) e[k*LEN_PRNG +: LEN_PRNG] = words[b*WPB+k];
                chk("beat_data", m_data, e);
                chk("beat_last", BW'(m_last), BW'(b == run_n - 1));
            end
            got_beats++;
        end
        stall_prev = m_valid === 1'b1 && m_ready === 1'b0 && rst === 1'b0;
        stall_data = m_data;
        stall_last = m_last;
        if (done === 1'b1) done_cnt++;
        @(posedge clk);
        #1;
    endtask

    task automatic step(input int pv, input int pr);
        if (last_acc || !z_valid) z = $urandom;
        z_valid = $urandom_range(99) < pv;
        m_ready = $urandom_range(99) < pr;
        tick();
    endtask

    task automatic begin_run(input int n);
        words.delete();
        run_n = n;
        got_beats = 0;
        z_valid = 0;
        start = 1;
        nbeats = 16'(n);
        tick();
        start = 0;
        nbeats = 16'hffff;
    endtask

    task automatic run_to_done(input int pv, input int pr, input int budget);
        int d0 = done_cnt;
        for (int i = 0; i < budget && done_cnt == d0; i++) step(pv, pr);
        z_valid = 0;
        m_ready = 1;
        chk("done_seen", BW'(done_cnt - d0), BW'(1));
    endtask

    initial begin
        int d0;
        rst = 1; start = 0; nbeats = 0; z = 0; z_valid = 0; m_ready = 1;
        repeat (3) tick();
        chk("rst_z_ready", BW'(z_ready), '0);
        chk("rst_m_valid", BW'(m_valid), '0);
        chk("rst_m_last", BW'(m_last), '0);
        chk("rst_busy", BW'(busy), '0);
        chk("rst_done", BW'(done), '0);
        chk("rst_m_data", m_data, '0);
        rst = 0;
        tick();

        // Single beat of 1,2,3,4 back-to-back.
        begin_run(1);
        for (int w = 1; w <= 4; w++) begin
            z = prng_t'(w);
            z_valid = 1;
            tick();
        end
        z_valid = 0;
        chk("b1_valid", BW'(m_valid), BW'(1));
        chk("b1_last", BW'(m_last), BW'(1));
        chk("b1_data", m_data, {32'd4, 32'd3, 32'd2, 32'd1});
        run_to_done(0, 100, 20);
        chk("b1_beats", BW'(got_beats), BW'(1));

        // Zero-length run.
        mv_seen = 0; zr_seen = 0;
        begin_run(0);
        chk("n0_done_early", BW'(done), '0);
        tick();
        chk("n0_done", BW'(done), BW'(1));
        tick(); tick();
        chk("n0_no_valid", BW'(mv_seen), '0);
        chk("n0_no_ready", BW'(zr_seen), '0);

        // Backpressure fills the FIFO, then drain.
        begin_run(6);
        repeat (30) step(100, 0);
        chk("bp_z_ready", BW'(z_ready), '0);
        chk("bp_words", BW'(words.size()), BW'(16));
        run_to_done(100, 100, 200);
        chk("bp_beats", BW'(got_beats), BW'(6));
        chk("bp_total", BW'(words.size()), BW'(24));

        // Long random run.
        begin_run(100);
        run_to_done(70, 60, 5000);
        chk("rnd_beats", BW'(got_beats), BW'(100));
        chk("rnd_words", BW'(words.size()), BW'(400));

        // Reset mid-run after 2 words of beat 3.
        begin_run(5);
        repeat (10) step(100, 0);
        chk("mr_words", BW'(words.size()), BW'(10));
        z_valid = 0;
        rst = 1;
        d0 = done_cnt;
        tick();
        rst = 0;
        chk("mr_z_ready", BW'(z_ready), '0);
        chk("mr_m_valid", BW'(m_valid), '0);
        chk("mr_m_last", BW'(m_last), '0);
        chk("mr_busy", BW'(busy), '0);
        chk("mr_done", BW'(done), '0);
        chk("mr_m_data", m_data, '0);
        m_ready = 1;
        repeat (5) tick();
        chk("mr_no_done", BW'(done_cnt - d0), '0);
        begin_run(1);
        run_to_done(100, 100, 50);
        chk("mr_clean_beats", BW'(got_beats), BW'(1));

        // Start pulsed mid-run is ignored.
        begin_run(3);
        repeat (5) step(100, 100);
        start = 1;
        nbeats = 16'd7;
        step(100, 100);
        start = 0;
        run_to_done(80, 80, 300);
        chk("ign_beats", BW'(got_beats), BW'(3));
        chk("ign_words", BW'(words.size()), BW'(12));
        repeat (3) tick();
        chk("ign_idle", BW'(busy), '0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/crg_out_packer.md
CRG_OUT_PACKER -- requirements
Module: crg_out_packer

Interface
REQ-001 Parameter WORDS_PER_BEAT, default 4: prng_t words packed per output beat.
REQ-002 Parameter FIFO_DEPTH, default 4: beat FIFO entries, power of two.
REQ-003 clk_i  input  1  sole clock; all logic on rising edge.
REQ-004 rst_i  input  1  reset, synchronous, active-high.
REQ-005 start_i  input  1  single-cycle request to begin a packing run.
REQ-006 nbeats_i  input  16  beats in the run; sampled with start_i.
REQ-007 z_i  input  prng_t  result word from the upstream subtract/XOR stage.
REQ-008 z_valid_i  input  1  z_i valid this cycle.
REQ-009 z_ready_o  output  1  block accepts z_i this cycle.
REQ-010 m_data_o  output  WORDS_PER_BEAT*LEN_PRNG  packed beat.
REQ-011 m_valid_o  output  1  m_data_o valid.
REQ-012 m_last_o  output  1  final beat of the run; qualified by m_valid_o.
REQ-013 m_ready_i  input  1  downstream accepts the beat.
REQ-014 busy_o  output  1  high in any state other than IDLE.
REQ-015 done_o  output  1  single-cycle pulse at run completion.

Function
REQ-016 FSM states: IDLE, RUN, FLUSH, DONE.
REQ-017 IDLE->RUN on start_i with nbeats_i!=0; IDLE->DONE on start_i with nbeats_i==0.
REQ-018 start_i outside IDLE ignored; nbeats_i latched only on accepted start_i.
REQ-019 z_ready_o = (state==RUN) && !fifo_full; word accepted when z_valid_i && z_ready_o.
REQ-020 Lane counter 0..WORDS_PER_BEAT-1; accepted word k lands at bits [(k+1)*LEN_PRNG-1 : k*LEN_PRNG]; counter increments per accepted word and wraps to 0.
REQ-021 Acceptance into the last lane pushes the completed beat into the FIFO in the same cycle; beat tagged last when beat counter == latched nbeats-1.
REQ-022 Pushing the last beat moves RUN->FLUSH; FLUSH->DONE when the FIFO is empty; DONE->IDLE after one cycle with done_o=1.
REQ-023 FIFO head drives m_data_o/m_last_o; m_valid_o = !fifo_empty; pop on m_valid_o && m_ready_i.
REQ-024 Latency: beat visible on m_valid_o the cycle after its last word is accepted.
REQ-025 Push and pop in the same cycle: both occur, occupancy unchanged; push never occurs while full, because z_ready_o is low when full.
REQ-026 Read/write pointers wrap modulo FIFO_DEPTH; occupancy counter covers 0..FIFO_DEPTH.
REQ-027 m_data_o, m_last_o and m_valid_o stay stable while m_valid_o && !m_ready_i.
REQ-028 Partial beats are never emitted; a run always delivers exactly nbeats beats.

Reset
REQ-029 rst_i forces IDLE, clears lane/beat counters, pointers and occupancy; z_ready_o, m_valid_o, m_last_o, busy_o and done_o read 0 the next cycle; m_data_o reads 0.
REQ-030 rst_i mid-run discards buffered beats and partial lanes, with no done_o pulse.

Structure
REQ-031 prng_t and LEN_PRNG come from TYPES; the FSM state enum pkr_state_t and OUT_W = WORDS_PER_BEAT*LEN_PRNG are added to TYPES.
REQ-032 One sub-module: beat_fifo, a parameterised synchronous FIFO holding {last, data} with full/empty flags.

Verification
REQ-033 start_i with nbeats=1, words 1,2,3,4 back-to-back, m_ready_i=1 -> one beat {4,3,2,1} (lane 0 = 1), m_last_o=1 the cycle after word 4, then done_o.
REQ-034 nbeats=0 -> done_o pulses 2 cycles after start_i; m_valid_o and z_ready_o never assert.
REQ-035 nbeats=6, m_ready_i=0 -> after 4 beats z_ready_o=0; raising m_ready_i drains 6 beats in order, last tagged only on beat 6.
REQ-036 Random z_valid_i and m_ready_i gaps, nbeats=100 -> scoreboard matches 400 words, no drops or duplicates, data stable under stall.
REQ-037 rst_i asserted after 2 words of beat 3 -> all outputs 0 next cycle; a new run with nbeats=1 yields a clean beat.
REQ-038 start_i pulsed during RUN -> ignored; beat count equals the original nbeats.
